// File: rtl/mmio_timer_device.sv
// Memory-mapped timer peripheral: reloading 32-bit timer with interrupt,
// LED and seven-segment registers, and a free-running system tick counter.
module mmio_timer_device (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Address,
  input  logic [31:0] Write_Data,
  output logic [31:0] Read_Data,
  output logic        irq,
  output logic [7:0]  leds,
  output logic [11:0] digits
);

  localparam logic [29:0] BASE_WORD = 30'h1000_0000;
  localparam int NUM_REGS = 6;
  localparam int IDX_TH   = 0;
  localparam int IDX_TL   = 1;
  localparam int IDX_TCON = 2;
  localparam int IDX_LED  = 3;
  localparam int IDX_DIGI = 4;
  localparam int IDX_TICK = 5;

  logic [31:0] th_reg;
  logic [31:0] tl_reg;
  logic [2:0]  tcon_reg;
  logic [7:0]  led_reg;
  logic [11:0] digi_reg;
  logic [31:0] systick_reg;

  logic [29:0]         word_addr;
  logic [NUM_REGS-1:0] hit;
  logic [NUM_REGS-1:0] wr_en;
  logic                overflow;
  logic                unused_addr_bits;

  assign word_addr        = Address[31:2];
  assign unused_addr_bits = ^Address[1:0];

  // One exact-match comparator per mapped word.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_decode
      assign hit[gi]   = (word_addr == BASE_WORD + 30'(gi));
      assign wr_en[gi] = MemWrite && hit[gi];
    end
  endgenerate

  // Decided from the pre-write state of this cycle.
  assign overflow = tcon_reg[0] && (tl_reg == 32'hFFFF_FFFF);

  always_comb begin
    Read_Data = 32'h0;
    if (MemRead) begin
      if (hit[IDX_TH])        Read_Data = th_reg;
      else if (hit[IDX_TL])   Read_Data = tl_reg;
      else if (hit[IDX_TCON]) Read_Data = {29'h0, tcon_reg};
      else if (hit[IDX_LED])  Read_Data = {24'h0, led_reg};
      else if (hit[IDX_DIGI]) Read_Data = {20'h0, digi_reg};
      else if (hit[IDX_TICK]) Read_Data = systick_reg;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      th_reg   <= 32'h0;
      led_reg  <= 8'h0;
      digi_reg <= 12'h0;
    end else begin
      if (wr_en[IDX_TH])   th_reg   <= Write_Data;
      if (wr_en[IDX_LED])  led_reg  <= Write_Data[7:0];
      if (wr_en[IDX_DIGI]) digi_reg <= Write_Data[11:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tl_reg <= 32'h0;
    end else if (wr_en[IDX_TL]) begin
      tl_reg <= Write_Data;
    end else if (tcon_reg[0]) begin
      tl_reg <= overflow ? th_reg : tl_reg + 32'd1;
    end
  end

  // A CPU write landing on an overflow still latches the interrupt if it enables it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tcon_reg <= 3'b000;
    end else if (wr_en[IDX_TCON]) begin
      tcon_reg <= {Write_Data[2] | (overflow & Write_Data[1]), Write_Data[1:0]};
    end else if (overflow && tcon_reg[1]) begin
      tcon_reg[2] <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) systick_reg <= 32'h0;
    else       systick_reg <= systick_reg + 32'd1;
  end

  assign irq    = tcon_reg[1] & tcon_reg[2];
  assign leds   = led_reg;
  assign digits = digi_reg;

endmodule

// File: tb/tb_mmio_timer_device.sv
// Directed self-checking bench for mmio_timer_device: timer reload, interrupt
// logic, write/overflow collisions, bus decode and asynchronous reset.
module tb_mmio_timer_device;

  localparam logic [31:0] A_TH   = 32'h4000_0000;
  localparam logic [31:0] A_TL   = 32'h4000_0004;
  localparam logic [31:0] A_TCON = 32'h4000_0008;
  localparam logic [31:0] A_LED  = 32'h4000_000C;
  localparam logic [31:0] A_DIGI = 32'h4000_0010;
  localparam logic [31:0] A_TICK = 32'h4000_0014;
  localparam logic [31:0] A_MISS = 32'h4000_0018;

  logic        clk;
  logic        reset;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Address;
  logic [31:0] Write_Data;
  logic [31:0] Read_Data;
  logic        irq;
  logic [7:0]  leds;
  logic [11:0] digits;

  int n_checks;
  int n_fails;

  mmio_timer_device dut (
    .clk        (clk),
    .reset      (reset),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .Address    (Address),
    .Write_Data (Write_Data),
    .Read_Data  (Read_Data),
    .irq        (irq),
    .leds       (leds),
    .digits     (digits)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Drives one write cycle spanning a single rising edge.
  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    Address    = addr;
    Write_Data = data;
    MemWrite   = 1'b1;
    @(negedge clk);
    MemWrite   = 1'b0;
    Write_Data = 32'h0;
    Address    = 32'h0;
    $display("wr addr=0x%08h data=0x%08h", addr, data);
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
    Address = addr;
    MemRead = 1'b1;
    #1;
    data    = Read_Data;
    MemRead = 1'b0;
    Address = 32'h0;
  endtask

  task automatic check_rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(addr, d);
    $display("rd addr=0x%08h data=0x%08h", addr, d);
    check_eq(tag, d, exp);
  endtask

  initial begin
    logic [31:0] tick0;
    logic [31:0] d;
    n_checks   = 0;
    n_fails    = 0;
    reset      = 1'b1;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    Address    = 32'h0;
    Write_Data = 32'h0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    check_eq("rst_irq", {31'h0, irq}, 32'h0);
    check_rd("rst_tl", A_TL, 32'h0);
    check_rd("rst_tcon", A_TCON, 32'h0);
    check_rd("rst_tick", A_TICK, 32'h0);

    // Reload with interrupt enabled
    bus_write(A_TH, 32'hFFFF_FFF0);
    bus_write(A_TL, 32'hFFFF_FFFE);
    bus_write(A_TCON, 32'h3);
    check_rd("rl_tl_hold", A_TL, 32'hFFFF_FFFE);
    @(negedge clk);
    check_rd("rl_tl_1", A_TL, 32'hFFFF_FFFF);
    @(negedge clk);
    check_rd("rl_tl_2", A_TL, 32'hFFFF_FFF0);
    check_rd("rl_tcon_2", A_TCON, 32'h7);
    check_eq("rl_irq_2", {31'h0, irq}, 32'h1);
    @(negedge clk);
    check_rd("rl_tl_3", A_TL, 32'hFFFF_FFF1);
    bus_write(A_TCON, 32'h0);
    check_eq("rl_irq_clr", {31'h0, irq}, 32'h0);
    check_rd("rl_tcon_clr", A_TCON, 32'h0);

    // Reload with interrupt disabled
    bus_write(A_TL, 32'hFFFF_FFFE);
    bus_write(A_TCON, 32'h1);
    @(negedge clk);
    check_rd("ie_tl_1", A_TL, 32'hFFFF_FFFF);
    @(negedge clk);
    check_rd("ie_tl_2", A_TL, 32'hFFFF_FFF0);
    check_rd("ie_tcon_2", A_TCON, 32'h1);
    check_eq("ie_irq_2", {31'h0, irq}, 32'h0);

    // TCON write landing on the overflow edge
    bus_write(A_TCON, 32'h0);
    bus_write(A_TL, 32'hFFFF_FFFE);
    bus_write(A_TCON, 32'h1);
    bus_write(A_TCON, 32'h3);
    check_rd("sim_tcon", A_TCON, 32'h7);
    check_eq("sim_irq", {31'h0, irq}, 32'h1);
    check_rd("sim_tl_rl", A_TL, 32'hFFFF_FFF0);

    // TL write landing on the overflow edge
    bus_write(A_TCON, 32'h0);
    bus_write(A_TL, 32'hFFFF_FFFE);
    bus_write(A_TCON, 32'h1);
    bus_write(A_TL, 32'h10);
    check_rd("sim_tl_wr", A_TL, 32'h10);
    check_rd("sim_tcon_b", A_TCON, 32'h1);
    bus_write(A_TCON, 32'h0);

    // Bus access and decode
    bus_write(A_LED, 32'h1AB);
    check_eq("led_out", {24'h0, leds}, 32'hAB);
    check_rd("led_rd", A_LED, 32'hAB);
    check_rd("led_lsb_ign", A_LED | 32'h3, 32'hAB);
    check_rd("led_miss_hi", 32'h5000_000C, 32'h0);
    bus_write(A_DIGI, 32'hFFFF);
    check_eq("digi_out", {20'h0, digits}, 32'hFFF);
    check_rd("digi_rd", A_DIGI, 32'hFFF);
    check_rd("miss_rd", A_MISS, 32'h0);
    Address = A_LED;
    #1;
    check_eq("noread_rd", Read_Data, 32'h0);
    Address = 32'h0;

    // Read-during-write returns the old LED value
    @(negedge clk);
    Address = A_LED; Write_Data = 32'h5C; MemRead = 1'b1; MemWrite = 1'b1;
    #1;
    check_eq("rdw_old", Read_Data, 32'hAB);
    @(negedge clk);
    MemWrite = 1'b0;
    #1;
    check_eq("rdw_new", Read_Data, 32'h5C);
    MemRead = 1'b0; Address = 32'h0; Write_Data = 32'h0;

    // SYSTICK write is ignored
    @(negedge clk);
    bus_read(A_TICK, tick0);
    Address = A_TICK; Write_Data = 32'h0; MemWrite = 1'b1;
    @(negedge clk);
    MemWrite = 1'b0;
    check_rd("tick_ro", A_TICK, tick0 + 32'd1);

    // Asynchronous reset between edges while the timer is running
    bus_write(A_TL, 32'h0);
    bus_write(A_TCON, 32'h7);
    check_eq("pre_rst_irq", {31'h0, irq}, 32'h1);
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    check_eq("ar_irq", {31'h0, irq}, 32'h0);
    check_eq("ar_leds", {24'h0, leds}, 32'h0);
    check_eq("ar_digits", {20'h0, digits}, 32'h0);
    check_rd("ar_th", A_TH, 32'h0);
    check_rd("ar_tl", A_TL, 32'h0);
    check_rd("ar_tcon", A_TCON, 32'h0);
    check_rd("ar_tick", A_TICK, 32'h0);
    Address = A_LED; Write_Data = 32'h55; MemWrite = 1'b1;
    @(negedge clk);
    reset = 1'b0; MemWrite = 1'b0; Address = 32'h0; Write_Data = 32'h0;
    check_eq("ar_wr_ign", {24'h0, leds}, 32'h0);
    check_rd("ar_tick_rel", A_TICK, 32'h0);
    @(negedge clk);
    check_rd("ar_tick_1", A_TICK, 32'h1);
    bus_read(A_TL, d);
    check_eq("ar_tl_hold", d, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
